instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage of the simple processor: holds the PC, reads instruction memory/cache over a busywait handshake, latches
//  the instruction word and drives OPCODE into the control unit. Computes the next PC (PC+4, jump, beq, bne) from the
//  decoded branch flags and the ALU ZERO flag; stalls on instruction- or data-side busywait.
// PARAMETERS
//  PC_W      32    width of PC and I_ADDRESS (byte address)
//  INSTR_W   32    instruction word width; OPCODE = INSTR[31:24], OFFSET = INSTR[23:16]
//  RESET_PC  0     PC value loaded on reset
// PORTS
//  CLK          in   1        system clock, rising edge
//  RESET_N      in   1        asynchronous, active-low reset
//  I_READ       out  1        instruction read request
//  I_ADDRESS    out  PC_W     instruction byte address (= PC)
//  I_BUSYWAIT   in   1        instruction memory busy; 0 = I_READDATA valid this cycle
//  I_READDATA   in   INSTR_W  instruction word from memory/cache
//  D_BUSYWAIT   in   1        data memory busy; holds the EXEC state
//  JUMP         in   1        from control unit: unconditional jump
//  BRANCH       in   1        from control unit: beq
//  BNE          in   1        from control unit: bne
//  ZERO         in   1        ALU zero flag
//  INSTRUCTION  out  INSTR_W  latched instruction register (IR)
//  OPCODE       out  8        IR[31:24], to control unit
//  PC           out  PC_W     PC of the instruction in IR
//  INSTR_VALID  out  1        IR holds a live instruction; register-file WRITE and data-memory accesses are gated by it
// BEHAVIOUR
//  Reset (RESET_N=0, async): PC=RESET_PC, IR=0, INSTR_VALID=0, I_READ=0, state=BOOT. All outputs settle without a clock edge.
//  FSM states: BOOT -> FETCH -> EXEC -> FETCH ...
//   BOOT : I_READ=0; exits to FETCH on the first rising edge after RESET_N goes high.
//   FETCH: I_READ=1, I_ADDRESS=PC held stable; INSTR_VALID=0. On an edge with I_BUSYWAIT=0: IR<=I_READDATA, go to EXEC.
//          I_BUSYWAIT=1 holds FETCH indefinitely; address and I_READ do not change.
//   EXEC : I_READ=0, INSTR_VALID=1, OPCODE=IR[31:24]. On an edge with D_BUSYWAIT=0: PC<=NEXT_PC, go to FETCH.
//          D_BUSYWAIT=1 holds EXEC; PC, IR and INSTR_VALID are held.
//  Latency: an instruction is valid one cycle after I_BUSYWAIT=0 is sampled. Minimum 2 cycles per instruction.
//  Next-PC arithmetic (mod 2^PC_W, wraps silently):
//   PC4    = PC + 4
//   TARGET = PC4 + sign_extend(OFFSET) << 2   (OFFSET is a signed 8-bit word offset)
//   TAKEN  = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);  NEXT_PC = TAKEN ? TARGET : PC4
//  Simultaneous flags: any true term takes the branch; BRANCH and BNE both asserted -> always taken.
//  JUMP/BRANCH/BNE/ZERO are sampled only at the EXEC exit edge; changes in other cycles are ignored.
//  RESET_N asserted mid-FETCH or mid-EXEC aborts immediately: I_READ drops, INSTR_VALID=0, PC=RESET_PC.
//  IR=0 decodes as opcode 0 (loadi); INSTR_VALID=0 keeps it from writing.
// CONFIGURATION
//  `IFU_PERF_CNT_EN defined: adds outputs RETIRED_CNT[31:0] and STALL_CNT[31:0], both reset to 0.
//   RETIRED_CNT increments on each EXEC->FETCH transition. STALL_CNT increments every cycle spent in FETCH with I_BUSYWAIT=1
//   or in EXEC with D_BUSYWAIT=1. Both wrap at 2^32.
//  Not defined: the counters and their ports are absent. Functional behaviour is identical.
// STRUCTURE
//  Shared package cpu_pkg: OPCODE constants (loadi=8'h00 ... j=8'h06, beq=8'h07, bne=8'h08), IFU state enum
//   {BOOT,FETCH,EXEC}, PC_W/INSTR_W defaults.
//  Sub-module ifu_next_pc: combinational PC4/TARGET/TAKEN/NEXT_PC. The top level holds the FSM, PC, IR and counters.
// TESTING
//  1 Reset/boot: RESET_N low with I_READDATA random -> PC=0, INSTR_VALID=0, I_READ=0; release -> I_READ=1 on the cycle after the first edge, I_ADDRESS=0.
//  2 Sequential: 3 fetches, I_BUSYWAIT=0, no flags -> I_ADDRESS 0,4,8; OPCODE tracks IR[31:24]; 2 cycles per instruction.
//  3 Branches at PC=0x10, OFFSET=8'hFE: JUMP -> 0x0C; BRANCH&ZERO=1 -> 0x0C; BRANCH&ZERO=0 -> 0x14; BNE&ZERO=0 -> 0x0C.
//  4 Stalls: I_BUSYWAIT high 5 cycles -> I_ADDRESS/I_READ stable, IR unchanged; D_BUSYWAIT high 3 cycles in EXEC -> PC held; with IFU_PERF_CNT_EN, STALL_CNT=8.
//  5 Wrap: PC=0xFFFFFFFC, no branch -> NEXT_PC=0; OFFSET=8'h7F at PC=0 -> 0x200.
//  6 Async reset mid-FETCH with I_BUSYWAIT=1 -> outputs reset same cycle with no clock edge; restart fetches from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch-unit state encoding and default widths.
`default_nettype none

package cpu_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;

  typedef enum logic [1:0] {
    IFU_BOOT  = 2'd0,
    IFU_FETCH = 2'd1,
    IFU_EXEC  = 2'd2
  } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ifu_next_pc.sv
// Next-PC selection: sequential PC+4 or PC-relative target from a signed 8-bit word offset.
`default_nettype none

module ifu_next_pc #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [7:0]      offset_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            bne_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] pc4;
  logic [PC_W-1:0] target;
  logic            taken;

  assign pc4 = pc_i + PC_W'(4);
  // Word offset: sign-extend and scale by 4; the sum wraps modulo 2^PC_W.
  assign target    = pc4 + {{(PC_W-10){offset_i[7]}}, offset_i, 2'b00};
  assign taken     = jump_i | (branch_i & zero_i) | (bne_i & ~zero_i);
  assign next_pc_o = taken ? target : pc4;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, instruction register and BOOT/FETCH/EXEC sequencing over busywait handshakes.
// Optional IFU_PERF_CNT_EN adds retired-instruction and stall-cycle counters.
`default_nettype none

module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  output logic               I_READ,
  output logic [PC_W-1:0]    I_ADDRESS,
  input  logic               I_BUSYWAIT,
  input  logic [INSTR_W-1:0] I_READDATA,
  input  logic               D_BUSYWAIT,
  input  logic               JUMP,
  input  logic               BRANCH,
  input  logic               BNE,
  input  logic               ZERO,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic [7:0]         OPCODE,
  output logic [PC_W-1:0]    PC,
  output logic               INSTR_VALID
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        RETIRED_CNT,
  output logic [31:0]        STALL_CNT
`endif
);

  ifu_state_e         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    next_pc;

  ifu_next_pc #(.PC_W(PC_W)) u_next_pc (
    .pc_i      (pc_q),
    .offset_i  (ir_q[INSTR_W-9 -: 8]),
    .jump_i    (JUMP),
    .branch_i  (BRANCH),
    .bne_i     (BNE),
    .zero_i    (ZERO),
    .next_pc_o (next_pc)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IFU_BOOT;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    I_READ      = 1'b0;
    INSTR_VALID = 1'b0;
    case (state_q)
      IFU_BOOT: state_d = IFU_FETCH;
      IFU_FETCH: begin
        I_READ = 1'b1;
        if (!I_BUSYWAIT) begin
          ir_d    = I_READDATA;
          state_d = IFU_EXEC;
        end
      end
      IFU_EXEC: begin
        INSTR_VALID = 1'b1;
        // Branch flags only matter on the edge that leaves EXEC.
        if (!D_BUSYWAIT) begin
          pc_d    = next_pc;
          state_d = IFU_FETCH;
        end
      end
      default: state_d = IFU_BOOT;
    endcase
  end

  assign I_ADDRESS   = pc_q;
  assign PC          = pc_q;
  assign INSTRUCTION = ir_q;
  assign OPCODE      = ir_q[INSTR_W-1 -: 8];

`ifdef IFU_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] stall_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (state_q == IFU_EXEC && !D_BUSYWAIT)
        retired_q <= retired_q + 32'd1;
      if ((state_q == IFU_FETCH && I_BUSYWAIT) || (state_q == IFU_EXEC && D_BUSYWAIT))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign RETIRED_CNT = retired_q;
  assign STALL_CNT   = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a PC-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        I_READ;
  logic [31:0] I_ADDRESS;
  logic        I_BUSYWAIT = 1'b0;
  logic [31:0] I_READDATA = '0;
  logic        D_BUSYWAIT = 1'b0;
  logic        JUMP = 1'b0, BRANCH = 1'b0, BNE = 1'b0, ZERO = 1'b0;
  logic [31:0] INSTRUCTION;
  logic [7:0]  OPCODE;
  logic [31:0] PC;
  logic        INSTR_VALID;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] RETIRED_CNT, STALL_CNT;
`endif

  instr_fetch_unit dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .I_READ      (I_READ),
    .I_ADDRESS   (I_ADDRESS),
    .I_BUSYWAIT  (I_BUSYWAIT),
    .I_READDATA  (I_READDATA),
    .D_BUSYWAIT  (D_BUSYWAIT),
    .JUMP        (JUMP),
    .BRANCH      (BRANCH),
    .BNE         (BNE),
    .ZERO        (ZERO),
    .INSTRUCTION (INSTRUCTION),
    .OPCODE      (OPCODE),
    .PC          (PC),
    .INSTR_VALID (INSTR_VALID)
`ifdef IFU_PERF_CNT_EN
    ,
    .RETIRED_CNT (RETIRED_CNT),
    .STALL_CNT   (STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: PC of the next fetch, last latched word, counter totals.
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  int          m_retired;
  int          m_stall;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                           input bit j, input bit b, input bit bn, input bit z);
    byte off;
    bit  taken;
    off   = byte'(word[23:16]);
    taken = j || (b && z) || (bn && !z);
    if (taken) return pc + 32'(4 + 4 * int'(off));
    return pc + 32'd4;
  endfunction

  task automatic rand_flags();
    JUMP   = 1'($urandom);
    BRANCH = 1'($urandom);
    BNE    = 1'($urandom);
    ZERO   = 1'($urandom);
  endtask

  task automatic check_counters();
`ifdef IFU_PERF_CNT_EN
    chk("retired_cnt", RETIRED_CNT, 32'(m_retired));
    chk("stall_cnt", STALL_CNT, 32'(m_stall));
`endif
  endtask

  task automatic do_reset();
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_iread", {31'd0, I_READ}, 32'd0);
    chk("rst_ivalid", {31'd0, INSTR_VALID}, 32'd0);
    chk("rst_pc", PC, 32'd0);
    chk("rst_ir", INSTRUCTION, 32'd0);
    m_pc = 32'd0; m_ir = 32'd0; m_retired = 0; m_stall = 0;
    check_counters();
    repeat (2) begin
      I_READDATA = $urandom;
      step();
    end
    RESET_N = 1'b1;
    chk("boot_iread", {31'd0, I_READ}, 32'd0);
    step();
    chk("boot_fetch_iread", {31'd0, I_READ}, 32'd1);
    chk("boot_fetch_addr", I_ADDRESS, 32'd0);
  endtask

  // One instruction: ib fetch-stall cycles, db exec-stall cycles, then exit EXEC with the given flags.
  task automatic do_instr(input logic [31:0] word, input int ib, input int db,
                          input bit j, input bit b, input bit bn, input bit z);
    chk("fetch_addr", I_ADDRESS, m_pc);
    chk("fetch_iread", {31'd0, I_READ}, 32'd1);
    chk("fetch_ivalid", {31'd0, INSTR_VALID}, 32'd0);
    I_BUSYWAIT = 1'b1;
    for (int k = 0; k < ib; k++) begin
      I_READDATA = $urandom;
      rand_flags();
      step();
      m_stall++;
      chk("istall_addr", I_ADDRESS, m_pc);
      chk("istall_iread", {31'd0, I_READ}, 32'd1);
      chk("istall_ir", INSTRUCTION, m_ir);
    end
    I_BUSYWAIT = 1'b0;
    I_READDATA = word;
    D_BUSYWAIT = 1'b0;
    step();
    m_ir = word;
    chk("exec_ir", INSTRUCTION, word);
    chk("exec_opcode", {24'd0, OPCODE}, {24'd0, word[31:24]});
    chk("exec_ivalid", {31'd0, INSTR_VALID}, 32'd1);
    chk("exec_iread", {31'd0, I_READ}, 32'd0);
    chk("exec_pc", PC, m_pc);
    I_READDATA = $urandom;
    I_BUSYWAIT = 1'($urandom);
    D_BUSYWAIT = 1'b1;
    for (int k = 0; k < db; k++) begin
      rand_flags();
      step();
      m_stall++;
      chk("dstall_pc", PC, m_pc);
      chk("dstall_ivalid", {31'd0, INSTR_VALID}, 32'd1);
      chk("dstall_ir", INSTRUCTION, m_ir);
    end
    D_BUSYWAIT = 1'b0;
    JUMP = j; BRANCH = b; BNE = bn; ZERO = z;
    step();
    m_pc = ref_next(m_pc, m_ir, j, b, bn, z);
    m_retired++;
    JUMP = 1'b0; BRANCH = 1'b0; BNE = 1'b0; ZERO = 1'b0;
    I_BUSYWAIT = 1'b0;
    chk("next_addr", I_ADDRESS, m_pc);
    chk("next_iread", {31'd0, I_READ}, 32'd1);
    check_counters();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] br_word;
    logic [31:0] s0;
    br_word = {8'h07, 8'hFE, 16'h1234};

    do_reset();

    // Sequential fetches, no stalls.
    do_instr(32'h0102_0304, 0, 0, 0, 0, 0, 0);
    chk("seq_addr4", I_ADDRESS, 32'h4);
    do_instr(32'h0211_2233, 0, 0, 0, 0, 0, 0);
    chk("seq_addr8", I_ADDRESS, 32'h8);
    do_instr(32'h03AA_BBCC, 0, 0, 0, 0, 0, 0);
    do_instr(32'h0400_0000, 0, 0, 0, 0, 0, 0);
    chk("seq_addr10", I_ADDRESS, 32'h10);

    // Branch cases from PC 0x10 with offset -2 words.
    do_instr(br_word, 0, 0, 1, 0, 0, 0);
    chk("jump_target", I_ADDRESS, 32'h0C);
    do_instr(32'h0500_0000, 0, 0, 0, 0, 0, 0);
    do_instr(br_word, 0, 0, 0, 1, 0, 1);
    chk("beq_taken", I_ADDRESS, 32'h0C);
    do_instr(32'h0500_0000, 0, 0, 0, 0, 0, 0);
    do_instr(br_word, 0, 0, 0, 1, 0, 0);
    chk("beq_not_taken", I_ADDRESS, 32'h14);
    do_instr(br_word, 0, 0, 1, 0, 0, 0);
    chk("back_to_10", I_ADDRESS, 32'h10);
    do_instr(br_word, 0, 0, 0, 0, 1, 0);
    chk("bne_taken", I_ADDRESS, 32'h0C);
    do_instr(br_word, 0, 0, 0, 1, 1, 1);
    chk("beq_bne_both", I_ADDRESS, 32'h08);

    // Stalls: 5 fetch-side and 3 data-side cycles.
`ifdef IFU_PERF_CNT_EN
    s0 = STALL_CNT;
`else
    s0 = 32'd0;
`endif
    do_instr(32'h0612_3456, 5, 3, 0, 0, 0, 0);
`ifdef IFU_PERF_CNT_EN
    chk("stall_delta", STALL_CNT - s0, 32'd8);
`endif

    // Wrap-around: reach 0xFFFFFFFC by a backward jump from 0.
    do_reset();
    do_instr({8'h06, 8'hFE, 16'h0}, 0, 0, 1, 0, 0, 0);
    chk("wrap_top", I_ADDRESS, 32'hFFFF_FFFC);
    do_instr(32'h0100_0000, 0, 0, 0, 0, 0, 0);
    chk("wrap_zero", I_ADDRESS, 32'h0);
    do_instr({8'h06, 8'h7F, 16'h0}, 0, 0, 1, 0, 0, 0);
    chk("fwd_max", I_ADDRESS, 32'h200);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      do_instr($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Async reset in the middle of a stalled fetch.
    I_BUSYWAIT = 1'b1;
    step();
    chk("pre_abort_iread", {31'd0, I_READ}, 32'd1);
    do_reset();
    I_BUSYWAIT = 1'b0;
    do_instr($urandom, 1, 1, 0, 0, 0, 0);
    do_instr($urandom, 0, 2, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
